keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives and decodes a 4x4 matrix keypad. Produces the 5-bit key stream consumed by the lock sequence FSM.
- keyout[4] is a one-cycle "new key" strobe; keyout[3:0] is the key code, held until the next key.
- Sits between the FPGA keypad pins and the lock FSM.
- Handles column scanning, row synchronisation, debounce, and press/release tracking.

Parameters:
- SCAN_DIV, 1000: clock cycles per column step. Must be >= 4.
- DEBOUNCE_CNT, 20: consecutive matching samples needed to accept a press, and consecutive all-high samples needed to accept a release. Must be >= 1.
- REPEAT_PERIODS, 500: sample periods between auto-repeat strobes. Used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col  output  4  keypad column drive, active-low, exactly one bit low at any time
- keyout  output  5  [4] one-cycle new-key strobe; [3:0] key code

Behaviour:
- Interface decision: one clock (clk). Reset rst is asynchronous and active-high, and returns every flop immediately to reset values.
- Reset values:
  - col=4'b1110
  - keyout=5'b00000
  - state=SCAN
  - divider, debounce and repeat counters = 0
  - captured row/col indices = 0
- Synchroniser: row passes through 2 flops before use. Only the synchronised value (rs) is used.
- Divider and sample point:
  - div counts 0..SCAN_DIV-1 and wraps.
  - A "sample" occurs on the cycle where div==SCAN_DIV-1.
- SCAN state:
  - On each sample, if rs has exactly one bit low: capture row index r and column index c, set match count to 1, freeze col, go to DEBOUNCE.
  - Otherwise (rs all-high or two or more bits low): rotate col 1110->1101->1011->0111->1110 on the same edge.
- DEBOUNCE state (col frozen):
  - On each sample, if rs equals the captured pattern, increment match count.
  - If rs differs: clear match count, go to SCAN, and advance col to the next column.
  - When match count reaches DEBOUNCE_CNT: on the next edge set keyout[3:0]=KEYMAP[r][c], pulse keyout[4] for exactly one cycle, and go to HELD.
  - With DEBOUNCE_CNT=1, the strobe is in the cycle after the detection sample.
- HELD state (col frozen):
  - Each all-high sample increments the release count; any low sample clears it.
  - When the release count reaches DEBOUNCE_CNT: go to SCAN and advance col.
  - No strobe is generated on release.
- Key map (row-major, rows 0..3, cols 0..3):
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: * 0 # D
  - Codes: digits map to their own value; A=0xA, B=0xB, C=0xC, D=0xD, *=0xE, #=0xF.
- Boundary conditions:
  - keyout[4] is never high for two consecutive cycles.
  - keyout[3:0] changes only on a strobe cycle.
  - A key held through reset generates a new press only after a full DEBOUNCE_CNT qualification following reset deassertion.
  - A second key pressed while in HELD is ignored, because only the frozen column is driven.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- When defined:
  - In HELD, while the captured pattern persists, a repeat counter counts samples.
  - Every REPEAT_PERIODS samples it re-pulses keyout[4] for one cycle with the same code.
  - The repeat counter clears on entry to HELD and on any non-matching sample.
- When undefined: the repeat counter and its logic are absent, and there is exactly one strobe per press.

Decomposition:
- Package keypad_pkg holds:
  - state_t enum {SCAN, DEBOUNCE, HELD}, 2 bits
  - KEYMAP constant, 4x4 array of 4-bit codes
  - COL_IDLE = 4'b1110
- Sub-module keypad_sync: parameterised-width 2-flop synchroniser with asynchronous active-high reset to all-ones. Instantiated once, width 4.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_PERIODS=2):
- Reset: assert rst mid-cycle with row=4'b1111 -> col=4'b1110 and keyout=0 immediately; after release, col rotates every 4 cycles.
- Press '5': drive row[1] low only while col=4'b1101, held steady -> exactly one strobe with keyout=5'b10101 after 3 matching samples; col stays at 1101. Release -> after 3 high samples, col advances to 1011 and no further strobe occurs.
- Bounce: press '#' (row3/col2) for 2 samples, then release -> no strobe; returns to SCAN; keyout[3:0] unchanged.
- Ghost: row[0] and row[2] both low on col0 -> no strobe; rotation continues.
- Reset mid-DEBOUNCE: assert rst after 2 matching samples of '0' -> immediate reset values. With the key still held after deassertion, the strobe with code 0x0 arrives only after 3 fresh samples.
- With KEYPAD_AUTOREPEAT_EN: hold 'A' for 3+4 samples -> 3 strobes total, each with code 0xA, spaced 8 cycles apart.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key map and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] COL_IDLE = 4'b1110;

  // KEYMAP[row][col]; '*' = 0xE, '#' = 0xF
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic one_low(input logic [3:0] v);
    return $countones(~v) == 1;
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!v[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser; resets to all-ones so idle (pulled-up) rows look released.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, debounce, press/release tracking, key strobe.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe a held key every REPEAT_PERIODS samples.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_CNT   = 20,
  parameter int REPEAT_PERIODS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] keyout
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CNT);

  logic [3:0] rs;

  keypad_sync #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (rs)
  );

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;   // match count in DEBOUNCE, release count in HELD
  logic [1:0]       r_q, r_d, c_q, c_d;
  logic [3:0]       code_q, code_d;
  logic             stb_q, stb_d;
  logic             sample;
  logic [3:0]       pat, col_nxt;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_PERIODS + 1);
  localparam logic [REP_W-1:0] REP_FULL = REP_W'(REPEAT_PERIODS);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  always_comb begin
    sample  = (div_q == DIV_LAST);
    pat     = ~(4'b0001 << r_q);
    col_nxt = {col_q[2:0], col_q[3]};
    div_d   = sample ? '0 : div_q + 1'b1;
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    c_d     = c_q;
    code_d  = code_q;
    stb_d   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      SCAN: begin
        if (sample) begin
          if (one_low(rs)) begin
            r_d     = low_idx(rs);
            c_d     = low_idx(col_q);
            cnt_d   = CNT_W'(1);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_nxt;
          end
        end
      end
      DEBOUNCE: begin
        // Qualification completes one edge after the final matching sample.
        if (cnt_q == CNT_FULL) begin
          code_d  = KEYMAP[r_q][c_q];
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end else if (sample) begin
          if (rs == pat) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = SCAN;
            col_d   = col_nxt;
          end
        end
      end
      HELD: begin
        if (sample) begin
          if (rs == 4'hF) begin
            if (cnt_q == CNT_FULL - 1'b1) begin
              cnt_d   = '0;
              state_d = SCAN;
              col_d   = col_nxt;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (rep_q == REP_FULL) begin
          stb_d = 1'b1;
          rep_d = '0;
        end else if (sample) begin
          rep_d = (rs == pat) ? rep_q + 1'b1 : '0;
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      div_q   <= '0;
      col_q   <= COL_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      code_q  <= '0;
      stb_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      c_q     <= c_d;
      code_q  <= code_d;
      stb_q   <= stb_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign col    = col_q;
  assign keyout = {stb_q, code_q};

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model plus a sample-level reference model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 3;
  localparam int RP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [4:0]  keyout;
  logic [15:0] keys = '0;   // keys[r*4+c] pressed
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC), .REPEAT_PERIODS(RP)) dut (
    .clk    (clk),
    .rst    (rst),
    .row    (row),
    .col    (col),
    .keyout (keyout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] phys_row(input int ci, input logic [15:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      if (k[rr*4+ci]) r[rr] = 1'b0;
    return r;
  endfunction

  always_comb begin
    int ci;
    ci = 0;
    for (int i = 0; i < 4; i++)
      if (!col[i]) ci = i;
    row = phys_row(ci, keys);
  end

  function automatic logic [3:0] col_of(input int ci);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ci);
  endfunction

  function automatic logic [3:0] key_code(input int r, input int c);
    string m;
    int ch;
    m  = "123A456B789C*0#D";
    ch = int'(m[r*4+c]);
    if (ch >= 48 && ch <= 57) return 4'(ch - 48);
    if (ch >= 65 && ch <= 68) return 4'(ch - 65 + 10);
    if (ch == 42) return 4'hE;
    return 4'hF;
  endfunction

  // Reference model: mode 0=scanning, 1=qualifying press, 2=key held
  typedef struct packed {
    int         mode;
    int         div;
    int         ci;
    int         r;
    int         c;
    int         cnt;
    int         rel;
    int         rep;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] code;
    logic       stb;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    m.s1 = 4'hF;
    m.s2 = 4'hF;
    return m;
  endfunction

  function automatic mdl_t model_next(input mdl_t m, input logic [3:0] row_now);
    mdl_t n;
    logic [3:0] rs, pat, one;
    int zeros, lowr;
    bit smp;
    n = m;
    n.stb = 1'b0;
    rs = m.s2;
    n.s2 = m.s1;
    n.s1 = row_now;
    smp = (m.div == SD - 1);
    n.div = smp ? 0 : m.div + 1;
    one = 4'b0001;
    pat = ~(one << m.r);
    zeros = 0;
    lowr = 0;
    for (int i = 0; i < 4; i++)
      if (!rs[i]) begin zeros++; lowr = i; end
    if (m.mode == 0) begin
      if (smp) begin
        if (zeros == 1) begin
          n.r = lowr; n.c = m.ci; n.cnt = 1; n.mode = 1;
        end else n.ci = (m.ci + 1) % 4;
      end
    end else if (m.mode == 1) begin
      if (m.cnt == DC) begin
        n.code = key_code(m.r, m.c); n.stb = 1'b1; n.mode = 2; n.rel = 0; n.rep = 0;
      end else if (smp) begin
        if (rs == pat) n.cnt = m.cnt + 1;
        else begin n.cnt = 0; n.mode = 0; n.ci = (m.ci + 1) % 4; end
      end
    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
      if (m.rep == RP) begin n.stb = 1'b1; n.rep = 0; end
      else if (smp) n.rep = (rs == pat) ? m.rep + 1 : 0;
`endif
      if (smp) begin
        if (rs == 4'hF) begin
          n.rel = m.rel + 1;
          if (n.rel == DC) begin n.rel = 0; n.mode = 0; n.ci = (m.ci + 1) % 4; end
        end else n.rel = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) mdl <= mdl_reset();
    else     mdl <= model_next(mdl, phys_row(mdl.ci, keys));
  end

  task automatic test_reset();
    keys = '0;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (col !== 4'b1110 || keyout !== 5'b00000) begin
      errors++; $display("FAIL reset_hold col=%b keyout=%b exp 1110/00000", col, keyout);
    end
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++;
      if (col !== col_of(mdl.ci) || keyout !== {mdl.stb, mdl.code}) begin
        errors++; $display("FAIL reset_rot col=%b keyout=%b exp %b/%b", col, keyout, col_of(mdl.ci), {mdl.stb, mdl.code});
      end
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checks++;
    if (col !== 4'b1110 || keyout !== 5'b00000) begin
      errors++; $display("FAIL reset_async col=%b keyout=%b exp 1110/00000", col, keyout);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_press_5();
    int n = 0, tp = -1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      checks++;
      if (col !== col_of(mdl.ci) || keyout !== {mdl.stb, mdl.code}) begin
        errors++; $display("FAIL press5 col=%b keyout=%b exp %b/%b", col, keyout, col_of(mdl.ci), {mdl.stb, mdl.code});
      end
      if (keyout[4]) n++;
      if (tp < 0 && col == 4'b1101) begin keys[5] = 1'b1; tp = i; end
      if (tp >= 0 && i == tp + 30) begin
        checks++;
        if (col !== 4'b1101 || n != 1 || keyout !== 5'b00101) begin
          errors++; $display("FAIL press5_held col=%b strobes=%0d keyout=%b exp 1101/1/00101", col, n, keyout);
        end
        keys = '0; n = 0;
      end
    end
    checks++;
    if (tp < 0 || n != 0 || keyout[3:0] !== 4'h5) begin
      errors++; $display("FAIL press5_release strobes=%0d code=%h exp 0/5", n, keyout[3:0]);
    end
  endtask

  task automatic test_bounce();
    int n = 0;
    bit pressed = 0, released = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (col !== col_of(mdl.ci) || keyout !== {mdl.stb, mdl.code}) begin
        errors++; $display("FAIL bounce col=%b keyout=%b exp %b/%b", col, keyout, col_of(mdl.ci), {mdl.stb, mdl.code});
      end
      if (keyout[4]) n++;
      if (!pressed && col == 4'b1011) begin keys[14] = 1'b1; pressed = 1; end
      if (pressed && !released && mdl.mode == 1 && mdl.cnt == 2) begin keys = '0; released = 1; end
    end
    checks++;
    if (!released || n != 0 || keyout[3:0] !== 4'h5) begin
      errors++; $display("FAIL bounce_result strobes=%0d code=%h exp 0/5", n, keyout[3:0]);
    end
  endtask

  task automatic test_ghost();
    int n = 0;
    keys = '0; keys[0] = 1'b1; keys[8] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (col !== col_of(mdl.ci) || keyout !== {mdl.stb, mdl.code}) begin
        errors++; $display("FAIL ghost col=%b keyout=%b exp %b/%b", col, keyout, col_of(mdl.ci), {mdl.stb, mdl.code});
      end
      if (keyout[4]) n++;
    end
    keys = '0;
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL ghost_strobe strobes=%0d exp 0", n);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit pressed = 0, hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      checks++;
      if (col !== col_of(mdl.ci) || keyout !== {mdl.stb, mdl.code}) begin
        errors++; $display("FAIL rstmid_pre col=%b keyout=%b exp %b/%b", col, keyout, col_of(mdl.ci), {mdl.stb, mdl.code});
      end
      if (!pressed && col == 4'b1101) begin keys[13] = 1'b1; pressed = 1; end
      if (mdl.mode == 1 && mdl.cnt == 2) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL rstmid_timeout qualifying=%0d exp 1", hit);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checks++;
    if (col !== 4'b1110 || keyout !== 5'b00000) begin
      errors++; $display("FAIL rstmid_async col=%b keyout=%b exp 1110/00000", col, keyout);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (col !== col_of(mdl.ci) || keyout !== {mdl.stb, mdl.code}) begin
        errors++; $display("FAIL rstmid_post col=%b keyout=%b exp %b/%b", col, keyout, col_of(mdl.ci), {mdl.stb, mdl.code});
      end
      if (keyout[4]) begin
        n++;
        checks++;
        if (i < 16) begin
          errors++; $display("FAIL rstmid_early strobe_cycle=%0d exp >=16", i);
        end
      end
    end
    checks++;
    if (n != 1 || keyout[3:0] !== 4'h0) begin
      errors++; $display("FAIL rstmid_strobe strobes=%0d code=%h exp 1/0", n, keyout[3:0]);
    end
    keys = '0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] prev_code;
    logic       prev_stb;
    int hold;
    prev_code = keyout[3:0];
    prev_stb  = keyout[4];
    for (int it = 0; it < 60; it++) begin
      keys = '0;
      keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 45);
      for (int i = 0; i < hold + 30; i++) begin
        if (i == hold) keys = '0;
        @(negedge clk);
        checks++;
        if (col !== col_of(mdl.ci) || keyout !== {mdl.stb, mdl.code}) begin
          errors++; $display("FAIL random col=%b keyout=%b exp %b/%b", col, keyout, col_of(mdl.ci), {mdl.stb, mdl.code});
        end
        checks++;
        if ((keyout[4] && prev_stb) || (!keyout[4] && keyout[3:0] !== prev_code)) begin
          errors++; $display("FAIL random_strobe keyout=%b prev_stb=%b prev_code=%h exp single-cycle strobe, stable code", keyout, prev_stb, prev_code);
        end
        prev_stb  = keyout[4];
        prev_code = keyout[3:0];
      end
    end
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int t[$];
    bit pressed = 0;
    for (int i = 0; i < 80 && t.size() < 3; i++) begin
      @(negedge clk);
      checks++;
      if (col !== col_of(mdl.ci) || keyout !== {mdl.stb, mdl.code}) begin
        errors++; $display("FAIL repeat col=%b keyout=%b exp %b/%b", col, keyout, col_of(mdl.ci), {mdl.stb, mdl.code});
      end
      if (keyout[4]) begin
        t.push_back(cyc);
        checks++;
        if (keyout[3:0] !== 4'hA) begin
          errors++; $display("FAIL repeat_code code=%h exp a", keyout[3:0]);
        end
      end
      if (!pressed && col == 4'b0111) begin keys[3] = 1'b1; pressed = 1; end
    end
    checks++;
    if (t.size() != 3 || t[1] - t[0] != 8 || t[2] - t[1] != 8) begin
      errors++; $display("FAIL repeat_spacing strobes=%0d exp 3 spaced 8", t.size());
    end
    keys = '0;
    repeat (30) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_press_5();
    test_bounce();
    test_ghost();
    test_reset_mid();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
